// File: rtl/pipe_add_sub_pkg.sv
// rtl/pipe_add_sub_pkg.sv - shared defaults and helpers for the segmented pipelined adder/subtractor
package pipe_add_sub_pkg;

    localparam int ADD_PIPE_DATA_LEN = 64;
    localparam int ADD_PIPE_SEG_LEN  = 16;
    localparam bit ADD_PIPE_WORD_EN  = 1'b1;
    localparam int WORD_LEN          = 32;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (a_msb != s_msb);
    endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// rtl/pipe_add_stage.sv - combinational SEG_LEN-bit adder slice with carry in/out
module pipe_add_stage #(
    parameter int SEG_LEN = 16
) (
    input  logic [SEG_LEN-1:0] a,
    input  logic [SEG_LEN-1:0] b,
    input  logic               cin,
    output logic [SEG_LEN-1:0] s,
    output logic               cout
);

    logic [SEG_LEN:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SEG_LEN{1'b0}}, cin};
    assign s     = total[SEG_LEN-1:0];
    assign cout  = total[SEG_LEN];

endmodule

// File: rtl/pipe_add_sub.sv
// rtl/pipe_add_sub.sv - pipelined add/sub resolving one SEG_LEN slice per stage, with stall, flush and word mode
module pipe_add_sub
    import pipe_add_sub_pkg::*;
#(
    parameter int DATA_LEN = ADD_PIPE_DATA_LEN,
    parameter int SEG_LEN  = ADD_PIPE_SEG_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] OP_A,
    input  logic [DATA_LEN-1:0] OP_B,
    input  logic                sub,
    input  logic                word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] Sum,
    output logic                overflow,
    output logic                Cout
);

    localparam int NUM_SEG = DATA_LEN / SEG_LEN;
    localparam int WMSB    = (DATA_LEN > WORD_LEN) ? WORD_LEN - 1 : DATA_LEN - 1;
    localparam int WSEG    = WMSB / SEG_LEN;
    localparam bit WORD_OK = ADD_PIPE_WORD_EN && (DATA_LEN > WORD_LEN);

    logic [NUM_SEG-1:0] vld;
    logic               adv;

    // Inter-stage registers; element NUM_SEG-1 is replaced by the output registers
    logic [DATA_LEN-1:0] a_q   [NUM_SEG];
    logic [DATA_LEN-1:0] b_q   [NUM_SEG];
    logic [DATA_LEN-1:0] s_q   [NUM_SEG];
    logic                c_q   [NUM_SEG];
    logic                w_q   [NUM_SEG];
    logic                c32_q [NUM_SEG];
    logic                v32_q [NUM_SEG];

    assign out_valid = vld[NUM_SEG-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int k = 1; k < NUM_SEG; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        logic [DATA_LEN-1:0] a_i;
        logic [DATA_LEN-1:0] b_i;
        logic [DATA_LEN-1:0] s_i;
        logic [DATA_LEN-1:0] s_nx;
        logic                c_i;
        logic                w_i;
        logic                c32_i;
        logic                v32_i;
        logic                c32_nx;
        logic                v32_nx;
        logic [SEG_LEN-1:0]  seg_s;
        logic                seg_c;

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1
            assign a_i   = OP_A;
            assign b_i   = OP_B ^ {DATA_LEN{sub}};
            assign s_i   = '0;
            assign c_i   = sub;
            assign w_i   = word & WORD_OK;
            assign c32_i = 1'b0;
            assign v32_i = 1'b0;
        end else begin : g_src
            assign a_i   = a_q[k-1];
            assign b_i   = b_q[k-1];
            assign s_i   = s_q[k-1];
            assign c_i   = c_q[k-1];
            assign w_i   = w_q[k-1];
            assign c32_i = c32_q[k-1];
            assign v32_i = v32_q[k-1];
        end

        pipe_add_stage #(
            .SEG_LEN(SEG_LEN)
        ) u_add (
            .a    (a_i[k*SEG_LEN +: SEG_LEN]),
            .b    (b_i[k*SEG_LEN +: SEG_LEN]),
            .cin  (c_i),
            .s    (seg_s),
            .cout (seg_c)
        );

        always_comb begin
            s_nx = s_i;
            s_nx[k*SEG_LEN +: SEG_LEN] = seg_s;
        end

        // The slice holding bit 31 captures the word-mode carry and overflow
        if (k == WSEG) begin : g_w32
            assign c32_nx = seg_c;
            assign v32_nx = signed_ovf(a_i[WMSB], b_i[WMSB], s_nx[WMSB]);
        end else begin : g_w32
            assign c32_nx = c32_i;
            assign v32_nx = v32_i;
        end

        if (k < NUM_SEG - 1) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q[k]   <= '0;
                    b_q[k]   <= '0;
                    s_q[k]   <= '0;
                    c_q[k]   <= 1'b0;
                    w_q[k]   <= 1'b0;
                    c32_q[k] <= 1'b0;
                    v32_q[k] <= 1'b0;
                end else if (adv) begin
                    a_q[k]   <= a_i;
                    b_q[k]   <= b_i;
                    s_q[k]   <= s_nx;
                    c_q[k]   <= seg_c;
                    w_q[k]   <= w_i;
                    c32_q[k] <= c32_nx;
                    v32_q[k] <= v32_nx;
                end
            end
        end else begin : g_reg
            logic [DATA_LEN-1:0] sum_fin;
            logic                cout_fin;
            logic                ovf_fin;

            if (WORD_OK) begin : g_sext
                assign sum_fin = w_i ? {{(DATA_LEN-WORD_LEN){s_nx[WMSB]}}, s_nx[WORD_LEN-1:0]} : s_nx;
            end else begin : g_sext
                assign sum_fin = s_nx;
            end

            assign cout_fin = w_i ? c32_nx : seg_c;
            assign ovf_fin  = w_i ? v32_nx
                                  : signed_ovf(a_i[DATA_LEN-1], b_i[DATA_LEN-1], s_nx[DATA_LEN-1]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    Sum      <= '0;
                    overflow <= 1'b0;
                    Cout     <= 1'b0;
                end else if (adv) begin
                    Sum      <= sum_fin;
                    overflow <= ovf_fin;
                    Cout     <= cout_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb/tb_pipe_add_sub.sv - directed vector bench for pipe_add_sub
module tb_pipe_add_sub;

    localparam int DATA_LEN = 64;
    localparam int SEG_LEN  = 16;
    localparam int NUM_SEG  = DATA_LEN / SEG_LEN;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] OP_A;
    logic [DATA_LEN-1:0] OP_B;
    logic                sub;
    logic                word;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] Sum;
    logic                overflow;
    logic                Cout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        word;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    pipe_add_sub #(
        .DATA_LEN(DATA_LEN),
        .SEG_LEN (SEG_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .sub       (sub),
        .word      (word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .overflow  (overflow),
        .Cout      (Cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        OP_A      = v.a;
        OP_B      = v.b;
        sub       = v.sub;
        word      = v.word;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, NUM_SEG);
        chk($sformatf("%s sum", tag), Sum, v.sum);
        chk($sformatf("%s cout", tag), Cout, v.cout);
        chk($sformatf("%s ovf", tag), overflow, v.ovf);
    endtask

    task automatic run_stream(input int stall_at);
        logic [63:0] ea[8];
        logic [63:0] eb[8];
        logic [63:0] es[8];
        logic        esub[8];
        int sent    = 0;
        int rcv     = 0;
        int first_c = -1;
        int last_c  = -1;
        for (int i = 0; i < 8; i++) begin
            ea[i]   = 64'h0F0F_F0F0_1234_FFFF + 64'h1111_0000_0001_8001 * 64'(i);
            eb[i]   = 64'h0000_FFFF_0000_8000 ^ 64'(i);
            esub[i] = (i % 2 == 1);
            es[i]   = esub[i] ? ea[i] - eb[i] : ea[i] + eb[i];
        end
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clk);
            out_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                OP_A = ea[sent];
                OP_B = eb[sent];
                sub  = esub[sent];
                word = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                chk("stall in_ready", in_ready, 0);
                chk("stall hold", Sum, es[rcv]);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream op %0d", rcv), Sum, es[rcv]);
                if (first_c < 0) first_c = c;
                last_c = c;
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream count", rcv, 8);
        if (stall_at < 0) chk("stream back-to-back", last_c - first_c, 7);
        repeat (NUM_SEG) @(negedge clk);
        chk("stream drained", out_valid, 0);
    endtask

    initial begin
        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2]  = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3]  = '{64'h0000_0000_7FFF_FFFF, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1};
        vecs[4]  = '{64'hDEAD_0000_7FFF_FFFF, 64'hDEAD_0000_0000_0001, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1};
        vecs[5]  = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[7]  = '{64'h1234_5678_0000_0000, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[8]  = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[9]  = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
        vecs[10] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[11] = '{64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0};
        vecs[12] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[13] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 64'h2, 1'b1, 1'b1};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        OP_A      = '0;
        OP_B      = '0;
        sub       = 1'b0;
        word      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset sum", Sum, 0);
        chk("reset ovf", overflow, 0);
        chk("reset cout", Cout, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);

        for (int i = 0; i < 13; i++) begin
            apply_vec(vecs[i], $sformatf("vec %0d", i));
        end

        run_stream(-1);
        run_stream(5);

        // Flush with three ops in flight and a fourth presented in the same cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            OP_A     = vecs[8 + i].a;
            OP_B     = vecs[8 + i].b;
            sub      = vecs[8 + i].sub;
            word     = vecs[8 + i].word;
        end
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        OP_A     = 64'h1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("flush quiet %0d", i), out_valid, 0);
            @(negedge clk);
        end
        apply_vec(vecs[11], "post-flush");

        // Asynchronous reset while a result is held at the output
        @(negedge clk);
        OP_A     = vecs[13].a;
        OP_B     = vecs[13].b;
        sub      = vecs[13].sub;
        word     = vecs[13].word;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("pre-reset sum", Sum, vecs[13].sum);
        chk("pre-reset cout", Cout, vecs[13].cout);
        chk("pre-reset ovf", overflow, vecs[13].ovf);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst sum", Sum, 0);
        chk("async rst ovf", overflow, 0);
        chk("async rst cout", Cout, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post-reset in_ready", in_ready, 1);
        apply_vec(vecs[11], "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
